// File: rtl/axi_cmd_sequencer.sv
// Command front-end for an AXI master: FIFO-queues client read/write commands, replays them one at a
// time as strobe/address/data pulses, and turns the observed R/B handshake (or a timeout) into a response.
module axi_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_timeout,
    output logic                       read,
    output logic                       write,
    output logic [ADDR_W-1:0]          address_to_read,
    output logic [ADDR_W-1:0]          address_to_write,
    output logic [DATA_W-1:0]          data_to_write,
    input  logic [DATA_W-1:0]          data_being_read,
    input  logic                       mon_r_valid,
    input  logic                       mon_r_ready,
    input  logic                       mon_b_valid,
    input  logic                       mon_b_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_ADDR, RD_WAIT, RD_CAP,
        WR_REQ, WR_ADDR, WR_DATA, WR_WAIT, RESP
    } state_t;

    cmd_t              mem_q [DEPTH];
    cmd_t              head;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] cur_wdata_q, cur_wdata_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d, rsp_rdata_q, rsp_rdata_d;
    logic              rsp_write_q, rsp_write_d, rsp_timeout_q, rsp_timeout_d;
    logic              push, pop, r_hs, b_hs, to_expired;

    // No pass-through: a full FIFO refuses even when a pop frees a slot this cycle.
    assign cmd_ready  = (count_q != CNT_W'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == IDLE) && (count_q != '0);
    assign head       = mem_q[rptr_q];
    assign r_hs       = mon_r_valid && mon_r_ready;
    assign b_hs       = mon_b_valid && mon_b_ready;
    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        wptr_d        = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d        = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d       = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        cur_addr_d    = cur_addr_q;
        cur_wdata_d   = cur_wdata_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_write_d   = rsp_write_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: if (pop) begin
                cur_addr_d    = head.addr;
                cur_wdata_d   = head.wdata;
                rsp_write_d   = head.write;
                rsp_rdata_d   = '0;
                rsp_timeout_d = 1'b0;
                state_d       = head.write ? WR_REQ : RD_REQ;
            end
            RD_REQ:  state_d = RD_ADDR;
            RD_ADDR: begin
                rd_addr_d = cur_addr_q;
                to_cnt_d  = '0;
                state_d   = RD_WAIT;
            end
            // Handshake is checked before expiry so a same-cycle handshake wins.
            RD_WAIT: begin
                if (r_hs) state_d = RD_CAP;
                else if (to_expired) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else to_cnt_d = to_cnt_q + TO_W'(1);
            end
            RD_CAP: begin
                rsp_rdata_d = data_being_read;
                state_d     = RESP;
            end
            WR_REQ:  state_d = WR_ADDR;
            WR_ADDR: begin
                wr_addr_d = cur_addr_q;
                state_d   = WR_DATA;
            end
            WR_DATA: begin
                wr_data_d = cur_wdata_q;
                to_cnt_d  = '0;
                state_d   = WR_WAIT;
            end
            WR_WAIT: begin
                if (b_hs) state_d = RESP;
                else if (to_expired) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else to_cnt_d = to_cnt_q + TO_W'(1);
            end
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Storage array carries no reset; occupancy is governed by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            to_cnt_q      <= '0;
            cur_addr_q    <= '0;
            cur_wdata_q   <= '0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rsp_rdata_q   <= '0;
            rsp_write_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            cur_addr_q    <= cur_addr_d;
            cur_wdata_q   <= cur_wdata_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_write_q   <= rsp_write_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign read             = (state_q == RD_REQ);
    assign write            = (state_q == WR_REQ);
    assign rsp_valid        = (state_q == RESP);
    assign busy             = (state_q != IDLE);
    assign rsp_write        = rsp_write_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_timeout      = rsp_timeout_q;
    assign address_to_read  = rd_addr_q;
    assign address_to_write = wr_addr_q;
    assign data_to_write    = wr_data_q;
    assign fifo_count       = count_q;
endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// Randomized bench for axi_cmd_sequencer: a command-level model (FIFO queue, memory, slave timing)
// predicts pulses, FIFO occupancy and each response, including timeouts and mid-transaction reset.
module tb_axi_cmd_sequencer;
  localparam int DEPTH = 4, AW = 4, DW = 8, T = 64;

  logic clk, rst_n;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic read, write;
  logic [AW-1:0] address_to_read, address_to_write;
  logic [DW-1:0] data_to_write, data_being_read;
  logic mon_r_valid, mon_r_ready, mon_b_valid, mon_b_ready, busy;
  logic [$clog2(DEPTH):0] fifo_count;

  axi_cmd_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .read(read), .write(write),
    .address_to_read(address_to_read), .address_to_write(address_to_write), .data_to_write(data_to_write),
    .data_being_read(data_being_read), .mon_r_valid(mon_r_valid), .mon_r_ready(mon_r_ready),
    .mon_b_valid(mon_b_valid), .mon_b_ready(mon_b_ready), .busy(busy), .fifo_count(fifo_count));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct { bit w; bit [AW-1:0] a; bit [DW-1:0] d; } cmd_s;
  cmd_s tosend[$], cq[$];
  bit [DW-1:0] mmem [16], smem [16];
  int errs = 0, checks = 0, s = 0, qcount = 0;
  bit idle = 1, pe_prev = 0, push_pend = 0, acc_pend = 0;
  // in-flight transaction as predicted by the model
  bit t_act = 0, t_w, t_to;
  int t_ws, t_d, t_exp;
  bit [AW-1:0] t_a;
  bit [DW-1:0] t_wd, t_rd;
  // stimulus modes
  bit hold_rsp = 0, force_to = 0, want_rst = 0, small_d = 0;
  int cmd_pct = 100, rsp_pct = 100;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @slot %0d: got %0h expected %0h", tag, s, got, exp);
    end
  endtask

  task automatic rst_chk();
    chk("rst_read", 32'(read), 0);            chk("rst_write", 32'(write), 0);
    chk("rst_a2r", 32'(address_to_read), 0);  chk("rst_a2w", 32'(address_to_write), 0);
    chk("rst_d2w", 32'(data_to_write), 0);    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_write", 32'(rsp_write), 0);  chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_to", 32'(rsp_timeout), 0);   chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(fifo_count), 0);     chk("rst_cmd_ready", 32'(cmd_ready), 1);
  endtask

  function automatic int pick_d();
    int r;
    if (force_to) return T;
    if (want_rst) return 5 + int'($urandom % 5);
    if (small_d) return int'($urandom % 3);
    r = int'($urandom % 12);
    if (r == 0) return T - 1;                        // handshake on the expiry cycle
    if (r == 1) return T + int'($urandom % 3);       // no handshake in window -> timeout
    return int'($urandom % 6);
  endfunction

  task automatic slot();
    bit ev, inwin, own_v, own_r;
    cmd_s c;
    @(posedge clk); #1;
    s++;
    if (!rst_n) rst_n = 1;
    if (push_pend) begin qcount++; push_pend = 0; end
    if (acc_pend) begin idle = 1; acc_pend = 0; end

    chk("pulse", 32'(read | write), 32'(pe_prev));
    if (pe_prev) begin
      c = cq[0];
      chk("pulse_kind", 32'({read, write}), c.w ? 2 'b01 : 2'b10);
      qcount--; idle = 0; t_act = 1;
      t_w = c.w; t_a = c.a; t_wd = c.d;
      t_ws = s + (c.w ? 3 : 2);
      t_d = pick_d();
      t_to = (t_d >= T);
      t_exp = t_ws + (t_to ? T : t_d + 1 + (c.w ? 0 : 1));
      t_rd = (!c.w && !t_to) ? mmem[c.a] : '0;
      if (c.w && !t_to) mmem[c.a] = c.d;
    end

    chk("fifo_count", 32'(fifo_count), 32'(qcount));
    chk("cmd_ready", 32'(cmd_ready), 32'(qcount < DEPTH));
    chk("busy", 32'(busy), 32'(!idle));
    ev = t_act && (s >= t_exp);
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk("rsp_write", 32'(rsp_write), 32'(t_w));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(t_rd));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(t_to));
    end
    if (t_act && s == t_ws) begin
      if (t_w) begin
        chk("address_to_write", 32'(address_to_write), 32'(t_a));
        chk("data_to_write", 32'(data_to_write), 32'(t_wd));
      end else chk("address_to_read", 32'(address_to_read), 32'(t_a));
    end

    // Abandon a read while it waits on R; no response may follow.
    if (want_rst && t_act && !t_w && s == t_ws + 1) begin
      cmd_valid = 0; rsp_ready = 0;
      mon_r_valid = 0; mon_r_ready = 0; mon_b_valid = 0; mon_b_ready = 0;
      rst_n = 0; #1;
      rst_chk();
      cq.delete(); qcount = 0; idle = 1; pe_prev = 0; push_pend = 0; acc_pend = 0;
      t_act = 0; want_rst = 0;
      return;
    end

    // Slave: one-sided noise on the awaited channel inside the window, free noise elsewhere.
    inwin = t_act && s >= t_ws && s <= t_ws + ((t_d < T) ? t_d : T - 1);
    mon_r_valid = 1'($urandom); mon_r_ready = 1'($urandom);
    mon_b_valid = 1'($urandom); mon_b_ready = 1'($urandom);
    if (inwin) begin
      own_v = 1'($urandom);
      own_r = own_v ? 1'b0 : 1'($urandom);
      if (s == t_ws + t_d) begin
        own_v = 1; own_r = 1;
        if (t_w) smem[address_to_write] = data_to_write;
      end
      if (t_w) begin mon_b_valid = own_v; mon_b_ready = own_r; end
      else     begin mon_r_valid = own_v; mon_r_ready = own_r; end
    end
    if (t_act && !t_w && !t_to && s == t_ws + t_d + 1) data_being_read = smem[address_to_read];
    else data_being_read = DW'($urandom);

    rsp_ready = hold_rsp ? 1'b0 : 1'(int'($urandom % 100) < rsp_pct);
    if (ev && rsp_ready) begin
      t_act = 0; void'(cq.pop_front()); acc_pend = 1;
    end

    if (tosend.size() > 0 && int'($urandom % 100) < cmd_pct) begin
      cmd_valid = 1; cmd_write = tosend[0].w; cmd_addr = tosend[0].a; cmd_wdata = tosend[0].d;
      if (qcount < DEPTH) begin push_pend = 1; cq.push_back(tosend.pop_front()); end
    end else begin
      cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    end
    pe_prev = idle && (qcount > 0);
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while ((tosend.size() > 0 || cq.size() > 0 || push_pend) && n < maxc) begin
      slot(); n++;
    end
    chk("drain_bound", 32'(n < maxc), 1);
  endtask

  task automatic add(bit w, bit [AW-1:0] a, bit [DW-1:0] d);
    cmd_s c;
    c.w = w; c.a = a; c.d = d;
    tosend.push_back(c);
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    data_being_read = 0; mon_r_valid = 0; mon_r_ready = 0; mon_b_valid = 0; mon_b_ready = 0;
    for (int i = 0; i < 16; i++) begin mmem[i] = 0; smem[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst_chk();

    // write 6<-AA then read 6 back
    small_d = 1;
    add(1, 6, 8'hAA); add(0, 6, 0);
    drain(300);
    small_d = 0;

    // responses held: FIFO fills to DEPTH and the extra command stalls
    hold_rsp = 1;
    for (int i = 0; i < 6; i++) add(1'($urandom), AW'($urandom), DW'($urandom));
    repeat (40) slot();
    chk("full_count", 32'(fifo_count), DEPTH);
    hold_rsp = 0;
    drain(3000);

    // forced write timeout
    force_to = 1;
    add(1, 4'h3, 8'h5C);
    drain(300);
    force_to = 0;

    // reset during a read wait, then normal traffic
    want_rst = 1;
    for (int i = 0; i < 3; i++) add(0, AW'($urandom), 0);
    drain(500);
    want_rst = 0;
    add(0, 6, 0); add(1, 9, 8'h3C); add(0, 9, 0);
    drain(500);

    // random mixed traffic with back-pressure; pointers wrap many times
    cmd_pct = 60; rsp_pct = 70;
    for (int i = 0; i < 150; i++) add(1'($urandom), AW'($urandom), DW'($urandom));
    drain(30000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
